// File: rtl/control_unit_if.sv
// Decode-stage bundle: IF/ID instruction fields in, RV32I control word and illegal status out.
interface control_unit_if;
    logic       instr_valid;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       register_write;
    logic [1:0] result_src;
    logic       mem_store;
    logic       mem_load;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic [3:0] alu_control;
    logic       alu_src;
    logic [2:0] imm_src;
    logic       illegal;
    logic       illegal_sticky;

    modport master (
        output instr_valid, op, funct3, funct7,
        input  register_write, result_src, mem_store, mem_load, branch, jal, jalr,
        input  alu_control, alu_src, imm_src, illegal, illegal_sticky
    );

    modport slave (
        input  instr_valid, op, funct3, funct7,
        output register_write, result_src, mem_store, mem_load, branch, jal, jalr,
        output alu_control, alu_src, imm_src, illegal, illegal_sticky
    );
endinterface

// File: rtl/control_unit.sv
// RV32I main decoder: combinational control word plus a sticky, clocked illegal-instruction flag.
module control_unit (
    input  logic           clk,
    input  logic           rst,
    control_unit_if.slave  bus
);

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluAnd  = 4'b0010;
    localparam logic [3:0] AluOr   = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0100;
    localparam logic [3:0] AluSll  = 4'b0101;
    localparam logic [3:0] AluSrl  = 4'b0110;
    localparam logic [3:0] AluSra  = 4'b0111;
    localparam logic [3:0] AluSlt  = 4'b1000;
    localparam logic [3:0] AluSltu = 4'b1001;
    localparam logic [3:0] AluImm  = 4'b1010;
    localparam logic [3:0] AluPc   = 4'b1011;

    localparam logic [2:0] ImmI     = 3'b000;
    localparam logic [2:0] ImmS     = 3'b001;
    localparam logic [2:0] ImmB     = 3'b010;
    localparam logic [2:0] ImmJ     = 3'b011;
    localparam logic [2:0] ImmShamt = 3'b100;
    localparam logic [2:0] ImmU     = 3'b101;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    logic       rw, ms, ml, br, j, jr, asrc, bad;
    logic [1:0] rs;
    logic [3:0] alu;
    logic [2:0] imm;
    logic       sticky_q, sticky_d;

    always_comb begin
        rw   = 1'b0;
        rs   = 2'b00;
        ms   = 1'b0;
        ml   = 1'b0;
        br   = 1'b0;
        j    = 1'b0;
        jr   = 1'b0;
        alu  = AluAdd;
        asrc = 1'b0;
        imm  = ImmI;
        bad  = 1'b0;
        case (bus.op)
            7'b0110111: begin rw = 1'b1; asrc = 1'b1; imm = ImmU; alu = AluImm; end
            7'b0010111: begin rw = 1'b1; asrc = 1'b1; imm = ImmU; alu = AluPc;  end
            7'b1101111: begin j = 1'b1; rw = 1'b1; rs = 2'b10; imm = ImmJ; end
            7'b1100111: begin
                jr = 1'b1; rw = 1'b1; rs = 2'b10; imm = ImmI;
                bad = (bus.funct3 != 3'b000);
            end
            7'b1100011: begin
                br = 1'b1; imm = ImmB; alu = AluSub;
                bad = (bus.funct3 == 3'b010) || (bus.funct3 == 3'b011);
            end
            7'b0000011: begin
                ml = 1'b1; rw = 1'b1; rs = 2'b01; asrc = 1'b1; imm = ImmI;
                bad = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11);
            end
            7'b0100011: begin
                ms = 1'b1; asrc = 1'b1; imm = ImmS;
                bad = (bus.funct3 > 3'b010);
            end
            7'b0010011: begin
                rw = 1'b1; asrc = 1'b1;
                case (bus.funct3)
                    3'b000: alu = AluAdd;
                    3'b010: alu = AluSlt;
                    3'b011: alu = AluSltu;
                    3'b100: alu = AluXor;
                    3'b110: alu = AluOr;
                    3'b111: alu = AluAnd;
                    3'b001: begin
                        imm = ImmShamt; alu = AluSll;
                        bad = (bus.funct7 != F7Base);
                    end
                    default: begin // 3'b101: shift right, arithmetic selected by funct7
                        imm = ImmShamt;
                        alu = (bus.funct7 == F7Alt) ? AluSra : AluSrl;
                        bad = (bus.funct7 != F7Base) && (bus.funct7 != F7Alt);
                    end
                endcase
            end
            7'b0110011: begin
                rw = 1'b1;
                if (bus.funct7 == F7Base) begin
                    case (bus.funct3)
                        3'b000:  alu = AluAdd;
                        3'b001:  alu = AluSll;
                        3'b010:  alu = AluSlt;
                        3'b011:  alu = AluSltu;
                        3'b100:  alu = AluXor;
                        3'b101:  alu = AluSrl;
                        3'b110:  alu = AluOr;
                        default: alu = AluAnd;
                    endcase
                end else if (bus.funct7 == F7Alt && bus.funct3 == 3'b000) begin
                    alu = AluSub;
                end else if (bus.funct7 == F7Alt && bus.funct3 == 3'b101) begin
                    alu = AluSra;
                end else begin
                    bad = 1'b1;
                end
            end
            7'b0001111, 7'b1110011: rs = 2'b00; // FENCE/SYSTEM: legal no-ops here
            default: bad = 1'b1;
        endcase

        // Bubbles and unsupported encodings must never write, touch memory or redirect.
        if (!bus.instr_valid || bad) begin
            rw   = 1'b0;
            rs   = 2'b00;
            ms   = 1'b0;
            ml   = 1'b0;
            br   = 1'b0;
            j    = 1'b0;
            jr   = 1'b0;
            alu  = AluAdd;
            asrc = 1'b0;
            imm  = ImmI;
        end

        bus.register_write = rw;
        bus.result_src     = rs;
        bus.mem_store      = ms;
        bus.mem_load       = ml;
        bus.branch         = br;
        bus.jal            = j;
        bus.jalr           = jr;
        bus.alu_control    = alu;
        bus.alu_src        = asrc;
        bus.imm_src        = imm;
        bus.illegal        = bus.instr_valid & bad;
    end

    assign sticky_d = sticky_q | bus.illegal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign bus.illegal_sticky = sticky_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed vector bench for control_unit: decode table plus sticky-flag reset sequences.
module tb_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    control_unit_if bus ();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        valid;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Packing order: rw, result_src, mem_store, mem_load, branch, jal, jalr, alu, alu_src, imm, ill
    function automatic logic [16:0] w(input logic rw, input logic [1:0] rs, input logic ms,
                                      input logic ml, input logic br, input logic j,
                                      input logic jr, input logic [3:0] alu, input logic as,
                                      input logic [2:0] imm, input logic ill);
        return {rw, rs, ms, ml, br, j, jr, alu, as, imm, ill};
    endfunction

    function automatic logic [16:0] observed();
        return {bus.register_write, bus.result_src, bus.mem_store, bus.mem_load, bus.branch,
                bus.jal, bus.jalr, bus.alu_control, bus.alu_src, bus.imm_src, bus.illegal};
    endfunction

    task automatic apply(input logic [31:0] instr, input logic valid);
        bus.instr_valid = valid;
        bus.op          = instr[6:0];
        bus.funct3      = instr[14:12];
        bus.funct7      = instr[31:25];
    endtask

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [31:0] instr, input logic valid,
                       input logic [16:0] exp);
        vec_t v;
        v.name = name; v.instr = instr; v.valid = valid; v.exp = exp;
        vecs.push_back(v);
    endtask

    logic [16:0] ill_word;
    logic [16:0] add_word;

    initial begin
        ill_word = 17'd1;
        add_word = w(1, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 0, 3'b000, 0);

        add("add",      32'h002081B3, 1, add_word);
        add("sub",      32'h402081B3, 1, w(1, 2'b00, 0, 0, 0, 0, 0, 4'b0001, 0, 3'b000, 0));
        add("lw",       32'h00812283, 1, w(1, 2'b01, 0, 1, 0, 0, 0, 4'b0000, 1, 3'b000, 0));
        add("sw",       32'h00512423, 1, w(0, 2'b00, 1, 0, 0, 0, 0, 4'b0000, 1, 3'b001, 0));
        add("beq",      32'h00208463, 1, w(0, 2'b00, 0, 0, 1, 0, 0, 4'b0001, 0, 3'b010, 0));
        add("jal",      32'h008000EF, 1, w(1, 2'b10, 0, 0, 0, 1, 0, 4'b0000, 0, 3'b011, 0));
        add("srai",     32'h4030D093, 1, w(1, 2'b00, 0, 0, 0, 0, 0, 4'b0111, 1, 3'b100, 0));
        add("lui",      32'h123450B7, 1, w(1, 2'b00, 0, 0, 0, 0, 0, 4'b1010, 1, 3'b101, 0));
        add("all_ones", 32'hFFFFFFFF, 1, ill_word);
        add("all_ones_bubble", 32'hFFFFFFFF, 0, 17'd0);
        add("add_bubble", 32'h002081B3, 0, 17'd0);
        add("auipc",    32'h00000097, 1, w(1, 2'b00, 0, 0, 0, 0, 0, 4'b1011, 1, 3'b101, 0));
        add("jalr",     32'h000080E7, 1, w(1, 2'b10, 0, 0, 0, 0, 1, 4'b0000, 0, 3'b000, 0));
        add("jalr_f3",  32'h000090E7, 1, ill_word);
        add("br_f3_2",  32'h00002063, 1, ill_word);
        add("br_f3_3",  32'h00003063, 1, ill_word);
        add("blt",      32'h00004063, 1, w(0, 2'b00, 0, 0, 1, 0, 0, 4'b0001, 0, 3'b010, 0));
        add("ld_f3_3",  32'h00003003, 1, ill_word);
        add("ld_f3_6",  32'h00006003, 1, ill_word);
        add("lhu",      32'h00005003, 1, w(1, 2'b01, 0, 1, 0, 0, 0, 4'b0000, 1, 3'b000, 0));
        add("st_f3_3",  32'h00003023, 1, ill_word);
        add("sb",       32'h00000023, 1, w(0, 2'b00, 1, 0, 0, 0, 0, 4'b0000, 1, 3'b001, 0));
        add("slli",     32'h00101093, 1, w(1, 2'b00, 0, 0, 0, 0, 0, 4'b0101, 1, 3'b100, 0));
        add("slli_f7",  32'h40001013, 1, ill_word);
        add("srli",     32'h0010D093, 1, w(1, 2'b00, 0, 0, 0, 0, 0, 4'b0110, 1, 3'b100, 0));
        add("srxi_f7",  32'h0200D093, 1, ill_word);
        add("xori",     32'h0000C013, 1, w(1, 2'b00, 0, 0, 0, 0, 0, 4'b0100, 1, 3'b000, 0));
        add("sltiu",    32'h00003013, 1, w(1, 2'b00, 0, 0, 0, 0, 0, 4'b1001, 1, 3'b000, 0));
        add("andi",     32'h0000F013, 1, w(1, 2'b00, 0, 0, 0, 0, 0, 4'b0010, 1, 3'b000, 0));
        add("or",       32'h00006033, 1, w(1, 2'b00, 0, 0, 0, 0, 0, 4'b0011, 0, 3'b000, 0));
        add("slt",      32'h00002033, 1, w(1, 2'b00, 0, 0, 0, 0, 0, 4'b1000, 0, 3'b000, 0));
        add("sra",      32'h40005033, 1, w(1, 2'b00, 0, 0, 0, 0, 0, 4'b0111, 0, 3'b000, 0));
        add("op_alt_f3_1", 32'h40001033, 1, ill_word);
        add("op_mul",   32'h02000033, 1, ill_word);
        add("fence",    32'h0000000F, 1, 17'd0);
        add("ecall",    32'h00000073, 1, 17'd0);
        add("bad_op",   32'h0000002B, 1, ill_word);

        // Reset: sticky clear, decode still live.
        apply(32'h002081B3, 1'b1);
        #3;
        check("reset_sticky", {16'd0, bus.illegal_sticky}, 17'd0);
        check("reset_comb_add", observed(), add_word);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            apply(vecs[i].instr, vecs[i].valid);
            #1;
            check(vecs[i].name, observed(), vecs[i].exp);
        end

        // Sticky cleared asynchronously between edges.
        @(negedge clk);
        apply(32'h002081B3, 1'b1);
        #1;
        check("sticky_set_by_table", {16'd0, bus.illegal_sticky}, 17'd1);
        #2;
        rst = 1'b0;
        #1;
        check("sticky_async_clear", {16'd0, bus.illegal_sticky}, 17'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("sticky_stays_clear_legal", {16'd0, bus.illegal_sticky}, 17'd0);

        // A bubble with illegal bits must not set sticky.
        @(negedge clk);
        apply(32'hFFFFFFFF, 1'b0);
        @(posedge clk);
        #1;
        check("sticky_bubble_ignored", {16'd0, bus.illegal_sticky}, 17'd0);

        @(negedge clk);
        apply(32'hFFFFFFFF, 1'b1);
        #1;
        check("sticky_before_edge", {16'd0, bus.illegal_sticky}, 17'd0);
        @(posedge clk);
        #1;
        check("sticky_after_edge", {16'd0, bus.illegal_sticky}, 17'd1);
        apply(32'h002081B3, 1'b1);
        @(posedge clk);
        #1;
        check("sticky_holds", {16'd0, bus.illegal_sticky}, 17'd1);

        // Reset with an illegal instruction present: sticky clears, illegal stays combinational.
        @(negedge clk);
        apply(32'hFFFFFFFF, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_with_illegal_sticky", {16'd0, bus.illegal_sticky}, 17'd0);
        check("rst_with_illegal_comb", observed(), ill_word);
        @(posedge clk);
        #1;
        check("rst_held_sticky", {16'd0, bus.illegal_sticky}, 17'd0);
        @(negedge clk);
        apply(32'h002081B3, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_legal", {16'd0, bus.illegal_sticky}, 17'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
